vend_sched: RTL

VEND_SCHED -- requirements
Module: vend_sched

---
 rtl/vend_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vend_sched.sv
// Two-channel coin acceptor sharing one dispenser: per-channel credit, round-robin
// grant on ties, dispenser timeout with refund. All outputs are registered.
module vend_sched #(
    parameter int PRICE   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pi_half_a,
    input  logic       pi_half_b,
    input  logic       pi_one_a,
    input  logic       pi_one_b,
    input  logic       pi_disp_done,
    output logic       po_disp_en,
    output logic       po_disp_sel,
    output logic       po_cola_a,
    output logic       po_cola_b,
    output logic [1:0] po_change_a,
    output logic [1:0] po_change_b,
    output logic       po_refund_a,
    output logic       po_refund_b,
    output logic       po_reject_a,
    output logic       po_reject_b,
    output logic       po_fault,
    output logic [1:0] dbg_state,
    output logic [2:0] dbg_credit_a,
    output logic [2:0] dbg_credit_b
);

    localparam int                TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TO_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [2:0]        PRICE_C  = 3'(PRICE);
    localparam logic [1:0]        PRICE_LO = 2'(PRICE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DISP  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       credit_a;
    logic [2:0]       credit_b;
    logic [TMR_W-1:0] timer;
    logic             grant;
    logic             last_served;

    logic             pend_a;
    logic             pend_b;
    logic             idle_grant;
    logic [1:0]       change_a_val;
    logic [1:0]       change_b_val;

    always_comb begin
        pend_a       = (credit_a >= PRICE_C);
        pend_b       = (credit_b >= PRICE_C);
        // Both pending: serve whichever channel was not served last.
        idle_grant   = (pend_a && pend_b) ? ~last_served : ~pend_a;
        change_a_val = credit_a[1:0] - PRICE_LO;
        change_b_val = credit_b[1:0] - PRICE_LO;
    end

    // Dispenser handshake: po_disp_en is a level request held for the whole DISP
    // state; pi_disp_done is a one-cycle completion honoured only while in DISP,
    // and the request drops on the edge that sees it or on timeout.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            credit_a    <= '0;
            credit_b    <= '0;
            timer       <= '0;
            grant       <= 1'b0;
            last_served <= 1'b1;
            po_disp_en  <= 1'b0;
            po_disp_sel <= 1'b0;
            po_cola_a   <= 1'b0;
            po_cola_b   <= 1'b0;
            po_change_a <= '0;
            po_change_b <= '0;
            po_refund_a <= 1'b0;
            po_refund_b <= 1'b0;
            po_reject_a <= 1'b0;
            po_reject_b <= 1'b0;
            po_fault    <= 1'b0;
        end else begin
            po_cola_a   <= 1'b0;
            po_cola_b   <= 1'b0;
            po_change_a <= '0;
            po_change_b <= '0;
            po_refund_a <= 1'b0;
            po_refund_b <= 1'b0;
            po_fault    <= 1'b0;
            po_reject_a <= pend_a & (pi_half_a | pi_one_a);
            po_reject_b <= pend_b & (pi_half_b | pi_one_b);

            if (!pend_a) credit_a <= credit_a + {1'b0, pi_one_a, pi_half_a};
            if (!pend_b) credit_b <= credit_b + {1'b0, pi_one_b, pi_half_b};

            case (state)
                IDLE: begin
                    if (pend_a || pend_b) begin
                        grant       <= idle_grant;
                        timer       <= '0;
                        po_disp_en  <= 1'b1;
                        po_disp_sel <= idle_grant;
                        state       <= DISP;
                    end
                end
                DISP: begin
                    if (pi_disp_done) begin
                        po_disp_en  <= 1'b0;
                        po_disp_sel <= 1'b0;
                        if (grant) begin
                            po_cola_b   <= 1'b1;
                            po_change_b <= change_b_val;
                        end else begin
                            po_cola_a   <= 1'b1;
                            po_change_a <= change_a_val;
                        end
                        state <= DONE;
                    end else if (timer == TO_LAST) begin
                        po_disp_en  <= 1'b0;
                        po_disp_sel <= 1'b0;
                        po_fault    <= 1'b1;
                        if (grant) po_refund_b <= 1'b1;
                        else       po_refund_a <= 1'b1;
                        state <= ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE, ABORT: begin
                    // The granted channel is pending, so its coin update above is a no-op.
                    if (grant) credit_b <= '0;
                    else       credit_a <= '0;
                    last_served <= grant;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state    = state;
    assign dbg_credit_a = credit_a;
    assign dbg_credit_b = credit_b;

endmodule
